clock_set_ctrl: RTL and testbench
=================================

// Module: clock_set_ctrl
// PURPOSE
//  Sequencer for the digital clock's three BCD time counters: seconds (mod-60), minutes (mod-60), hours (mod-24).
//  Generates the 1 Hz tick and the cascaded enables in RUN mode.
//  Owns the time-set FSM driven by debounced key pulses; in set mode it steps the selected field via load/data.
// PARAMETERS
//  CLK_DIV   50_000_000  clk cycles per 1 s tick (>=4)
// PORTS
//  clk        in   1  system clock, all logic on posedge
//  rst_n      in   1  asynchronous active-low reset
//  key_mode   in   1  1-cycle pulse: advance FSM RUN->SET_H->SET_M->SET_S->RUN
//  key_inc    in   1  1-cycle pulse: +1 on selected field (set modes only)
//  key_dec    in   1  1-cycle pulse: -1 on selected field (set modes only)
//  sec_bcd    in   8  current seconds {tens,units} from counter
//  min_bcd    in   8  current minutes
//  hour_bcd   in   8  current hours
//  sec_en     out  1  count enable, seconds counter
//  min_en     out  1  count enable, minutes counter
//  hour_en    out  1  count enable, hours counter
//  sec_load   out  1  load strobe, seconds counter
//  min_load   out  1  load strobe, minutes counter
//  hour_load  out  1  load strobe, hours counter
//  load_data  out  8  BCD value shared by all load strobes
//  set_field  out  2  00 none, 01 hour, 10 min, 11 sec (display highlight)
//  blink_on   out  1  display gate for the selected field
// BEHAVIOUR
//  Reset: state RUN, prescaler 0, all outputs 0 except blink_on=1. Every output is registered.
//  RUN: the prescaler counts 0..CLK_DIV-1, and tick is asserted on the CLK_DIV-1 cycle.
//    sec_en=tick; min_en=tick&&sec==8'h59; hour_en=min_en&&min==8'h59; all enables are 1-cycle pulses.
//    These are registered one cycle after tick; the comparisons use the inputs sampled on the tick cycle.
//  key_mode advances the state on the next edge. Entering any SET state clears the prescaler and freezes it.
//    All *_en are 0 in SET states. Returning to RUN restarts the prescaler from 0, so the first tick comes CLK_DIV cycles later.
//  SET_x: key_inc/key_dec produce exactly one x_load pulse on the next cycle.
//    load_data = field stepped by the modulus: hour 23->00 / 00->23, min/sec 59->00 / 00->59.
//    Arithmetic is BCD per digit: units 9 carries to tens; units 0 on decrement borrows.
//  Out-of-range inputs (units>9, or a value >= modulus) load 00 on inc or dec.
//  Guard cycle: after a load pulse, inc/dec are ignored for 1 cycle so the counter output settles.
//  Simultaneous events:
//    key_mode together with inc/dec: mode wins, inc/dec dropped.
//    key_inc together with key_dec: both dropped.
//  Reset asserted mid-set returns to RUN immediately. Any pending load is discarded (load strobes go to 0 asynchronously).
//  load_data holds its last value when no strobe is active. Only one *_load is ever high at a time.
// CONFIGURATION
//  CLK_CTRL_BLINK_EN defined:
//    In SET states, blink_on toggles every CLK_DIV/2 cycles from a separate half-period counter. That counter restarts at blink_on=1 on every state change and every load.
//    In RUN, blink_on=1.
//  Not defined: blink_on tied to 1, half-period counter absent.
// STRUCTURE
//  Package clk_ctrl_pkg:
//    state encoding ST_RUN=0, ST_SET_H=1, ST_SET_M=2, ST_SET_S=3 (set_field = state);
//    BCD_MAX_SEC=8'h59, BCD_MAX_MIN=8'h59, BCD_MAX_HOUR=8'h23.
//  Sub-module bcd_step: combinational, inputs {val[7:0], max[7:0], dir}, output next[7:0].
//    Performs the wrap and out-of-range rules above. Instantiated once, muxed by state.
// TESTING
//  1 Reset, CLK_DIV=10, sec=00: the first sec_en pulse comes 10 cycles after rst_n deasserts; min_en/hour_en stay 0.
//  2 Cascade, RUN with sec=59, min=59, hour=23 at tick: sec_en, min_en and hour_en all pulse in the same cycle.
//  3 Mode cycling, 4 key_mode pulses: set_field 01,10,11,00; *_en silent during SET; after the return, first sec_en comes exactly CLK_DIV cycles later.
//  4 Wrap, SET_H with hour=23 and key_inc: hour_load=1, load_data=8'h00.
//    Same with hour=00 and key_dec: load_data=8'h23.
//    SET_M with min=8'h09 and key_inc: load_data=8'h10.
//  5 Conflicts:
//    key_inc+key_dec together: no load.
//    key_mode+key_inc together: state advances, no load.
//    key_inc on two consecutive cycles: only one load.
//    Out-of-range hour=8'h2A with key_inc: load_data=8'h00.
//  6 Reset mid-SET_M with key_inc in flight: min_load never asserts, state RUN; with CLK_CTRL_BLINK_EN, blink_on=1 and toggles at CLK_DIV/2 in SET.

Source files
------------

// File: rtl/clk_ctrl_pkg.sv
// Shared state encoding and BCD field limits for the digital clock set controller.
package clk_ctrl_pkg;

  // set_field is driven straight from the state register, so this encoding is also the display code
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_SET_H = 2'd1,
    ST_SET_M = 2'd2,
    ST_SET_S = 2'd3
  } state_t;

  localparam logic [7:0] BCD_MAX_SEC  = 8'h59;
  localparam logic [7:0] BCD_MAX_MIN  = 8'h59;
  localparam logic [7:0] BCD_MAX_HOUR = 8'h23;

endpackage

// File: rtl/clock_set_ctrl_bcd_step.sv
// Combinational BCD +/-1 with wrap at the field maximum; malformed or out-of-range values step to 00.
module bcd_step (
  input  logic [7:0] val,
  input  logic [7:0] max,
  input  logic       dir,   // 0 increment, 1 decrement
  output logic [7:0] next
);

  always_comb begin
    next = '0;
    if (val[3:0] > 4'd9 || val[7:4] > 4'd9 || val > max) begin
      next = '0;
    end else if (!dir) begin
      if (val == max)             next = '0;
      else if (val[3:0] == 4'd9)  next = {val[7:4] + 4'd1, 4'd0};
      else                        next = {val[7:4], val[3:0] + 4'd1};
    end else begin
      if (val == '0)              next = max;
      else if (val[3:0] == 4'd0)  next = {val[7:4] - 4'd1, 4'd9};
      else                        next = {val[7:4], val[3:0] - 4'd1};
    end
  end

endmodule

// File: rtl/clock_set_ctrl.sv
// Clock sequencer: 1 Hz tick, cascaded counter enables and the time-set FSM.
// Optional field blinking in set modes is built when CLK_CTRL_BLINK_EN is defined.
module clock_set_ctrl
  import clk_ctrl_pkg::*;
#(
  parameter int unsigned CLK_DIV = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_mode,
  input  logic       key_inc,
  input  logic       key_dec,
  input  logic [7:0] sec_bcd,
  input  logic [7:0] min_bcd,
  input  logic [7:0] hour_bcd,
  output logic       sec_en,
  output logic       min_en,
  output logic       hour_en,
  output logic       sec_load,
  output logic       min_load,
  output logic       hour_load,
  output logic [7:0] load_data,
  output logic [1:0] set_field,
  output logic       blink_on
);

  localparam int unsigned PW = $clog2(CLK_DIV);

  state_t        state, state_nx;
  logic [PW-1:0] presc, presc_nx;
  logic          tick;
  logic          step_req;
  logic [7:0]    step_val, step_max, step_next;
  logic [2:0]    load_sel;

  always_comb begin
    state_nx = state;
    if (key_mode) begin
      case (state)
        ST_RUN:   state_nx = ST_SET_H;
        ST_SET_H: state_nx = ST_SET_M;
        ST_SET_M: state_nx = ST_SET_S;
        default:  state_nx = ST_RUN;
      endcase
    end
  end

  // A tick on the same cycle as leaving RUN is suppressed so no enable leaks into SET_H
  always_comb begin
    tick     = (state == ST_RUN) && !key_mode && (presc == PW'(CLK_DIV - 1));
    presc_nx = presc + 1'b1;
    if (state != ST_RUN || key_mode || presc == PW'(CLK_DIV - 1))
      presc_nx = '0;
  end

  // Any active load strobe doubles as the one-cycle guard against stale counter values
  always_comb begin
    step_req = (state != ST_RUN) && !key_mode && (key_inc ^ key_dec) &&
               !(sec_load || min_load || hour_load);
    step_val = sec_bcd;
    step_max = BCD_MAX_SEC;
    load_sel = '0;
    case (state)
      ST_SET_H: begin step_val = hour_bcd; step_max = BCD_MAX_HOUR; load_sel = 3'b100; end
      ST_SET_M: begin step_val = min_bcd;  step_max = BCD_MAX_MIN;  load_sel = 3'b010; end
      ST_SET_S: begin step_val = sec_bcd;  step_max = BCD_MAX_SEC;  load_sel = 3'b001; end
      default:  ;
    endcase
  end

  bcd_step u_step (
    .val  (step_val),
    .max  (step_max),
    .dir  (key_dec),
    .next (step_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_RUN;
      presc     <= '0;
      sec_en    <= 1'b0;
      min_en    <= 1'b0;
      hour_en   <= 1'b0;
      sec_load  <= 1'b0;
      min_load  <= 1'b0;
      hour_load <= 1'b0;
      load_data <= '0;
    end else begin
      state   <= state_nx;
      presc   <= presc_nx;
      sec_en  <= tick;
      min_en  <= tick && (sec_bcd == BCD_MAX_SEC);
      hour_en <= tick && (sec_bcd == BCD_MAX_SEC) && (min_bcd == BCD_MAX_MIN);
      {hour_load, min_load, sec_load} <= step_req ? load_sel : 3'b000;
      if (step_req)
        load_data <= step_next;
    end
  end

  assign set_field = state;

`ifdef CLK_CTRL_BLINK_EN
  localparam int unsigned HALF = CLK_DIV / 2;
  localparam int unsigned HW   = $clog2(HALF);

  logic [HW-1:0] half_cnt;
  logic          blink_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      half_cnt <= '0;
      blink_q  <= 1'b1;
    end else if (state_nx == ST_RUN || state_nx != state || step_req) begin
      half_cnt <= '0;
      blink_q  <= 1'b1;
    end else if (half_cnt == HW'(HALF - 1)) begin
      half_cnt <= '0;
      blink_q  <= ~blink_q;
    end else begin
      half_cnt <= half_cnt + 1'b1;
    end
  end

  assign blink_on = blink_q;
`else
  assign blink_on = 1'b1;
`endif

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Self-checking bench for clock_set_ctrl: vector tables, hand sequences and a load scoreboard.
module tb_clock_set_ctrl;

  localparam int unsigned CLK_DIV = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       key_mode = 1'b0, key_inc = 1'b0, key_dec = 1'b0;
  logic [7:0] sec_bcd = 8'h00, min_bcd = 8'h00, hour_bcd = 8'h00;
  logic       sec_en, min_en, hour_en, sec_load, min_load, hour_load, blink_on;
  logic [7:0] load_data;
  logic [1:0] set_field;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [2:0] sel;
    logic [7:0] data;
  } load_t;

  load_t exp_q[$];

  typedef struct {
    logic [1:0] field;
    logic [7:0] val;
    logic       inc;
    logic       dec;
    logic       exp_load;
    logic [7:0] exp_data;
  } step_vec_t;

  typedef struct {
    logic [7:0] sec;
    logic [7:0] min;
    logic [7:0] hour;
    logic       exp_min;
    logic       exp_hour;
  } casc_vec_t;

  step_vec_t sv[12];
  casc_vec_t cv[4];

  always #5 clk = ~clk;

  clock_set_ctrl #(.CLK_DIV(CLK_DIV)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_mode  (key_mode),
    .key_inc   (key_inc),
    .key_dec   (key_dec),
    .sec_bcd   (sec_bcd),
    .min_bcd   (min_bcd),
    .hour_bcd  (hour_bcd),
    .sec_en    (sec_en),
    .min_en    (min_en),
    .hour_en   (hour_en),
    .sec_load  (sec_load),
    .min_load  (min_load),
    .hour_load (hour_load),
    .load_data (load_data),
    .set_field (set_field),
    .blink_on  (blink_on)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic m, input logic i, input logic d);
    key_mode = m; key_inc = i; key_dec = d;
    step();
    key_mode = 1'b0; key_inc = 1'b0; key_dec = 1'b0;
  endtask

  task automatic wait_sec_en(output int n);
    n = 0;
    for (int c = 1; c <= 25; c++) begin
      step();
      if (sec_en) begin
        n = c;
        break;
      end
    end
  endtask

  // Scoreboard: every load strobe must match the oldest expected load
  always @(negedge clk) begin
    if ({hour_load, min_load, sec_load} != 3'b000) begin
      load_t e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_load: got sel %b data %h expected no load",
                 {hour_load, min_load, sec_load}, load_data);
      end else begin
        e = exp_q.pop_front();
        if ({hour_load, min_load, sec_load} !== e.sel || load_data !== e.data) begin
          errors++;
          $display("FAIL load: got sel %b data %h expected sel %b data %h",
                   {hour_load, min_load, sec_load}, load_data, e.sel, e.data);
        end
      end
    end
  end

  initial begin
    int first, seen, n, en_cnt;

    sv[0]  = '{2'd1, 8'h23, 1'b1, 1'b0, 1'b1, 8'h00};
    sv[1]  = '{2'd1, 8'h00, 1'b0, 1'b1, 1'b1, 8'h23};
    sv[2]  = '{2'd2, 8'h09, 1'b1, 1'b0, 1'b1, 8'h10};
    sv[3]  = '{2'd2, 8'h59, 1'b1, 1'b0, 1'b1, 8'h00};
    sv[4]  = '{2'd2, 8'h00, 1'b0, 1'b1, 1'b1, 8'h59};
    sv[5]  = '{2'd3, 8'h40, 1'b0, 1'b1, 1'b1, 8'h39};
    sv[6]  = '{2'd3, 8'h59, 1'b1, 1'b0, 1'b1, 8'h00};
    sv[7]  = '{2'd3, 8'h05, 1'b1, 1'b0, 1'b1, 8'h06};
    sv[8]  = '{2'd1, 8'h2A, 1'b1, 1'b0, 1'b1, 8'h00};
    sv[9]  = '{2'd1, 8'h24, 1'b0, 1'b1, 1'b1, 8'h00};
    sv[10] = '{2'd1, 8'h19, 1'b1, 1'b0, 1'b1, 8'h20};
    sv[11] = '{2'd2, 8'h30, 1'b1, 1'b1, 1'b0, 8'h00};

    cv[0] = '{8'h59, 8'h59, 8'h23, 1'b1, 1'b1};
    cv[1] = '{8'h59, 8'h30, 8'h12, 1'b1, 1'b0};
    cv[2] = '{8'h30, 8'h59, 8'h23, 1'b0, 1'b0};
    cv[3] = '{8'h00, 8'h59, 8'h00, 1'b0, 1'b0};

    // Reset state
    #2 rst_n = 1'b0;
    step(); step();
    chk("reset_outputs",
        {sec_en, min_en, hour_en, sec_load, min_load, hour_load, load_data, set_field, blink_on},
        {6'b0, 8'h00, 2'b00, 1'b1});

    // First tick latency after reset release
    rst_n = 1'b1;
    first = 0; seen = 0;
    for (int c = 1; c <= 30; c++) begin
      step();
      if (sec_en && first == 0) first = c;
      if (min_en || hour_en) seen = 1;
    end
    chk("first_sec_en_after_reset", first, CLK_DIV);
    chk("no_min_hour_en_at_sec00", seen, 0);

    // Cascade table
    for (int k = 0; k < 4; k++) begin
      wait_sec_en(n);
      sec_bcd = cv[k].sec; min_bcd = cv[k].min; hour_bcd = cv[k].hour;
      wait_sec_en(n);
      if (n == 0) begin
        chk("cascade_timeout", 0, 1);
      end else begin
        chk("cascade_min_en", min_en, cv[k].exp_min);
        chk("cascade_hour_en", hour_en, cv[k].exp_hour);
      end
    end

    // Mode cycling, enables silent in set modes, restart latency
    sec_bcd = 8'h59; min_bcd = 8'h59; hour_bcd = 8'h23;
    en_cnt = 0;
    for (int f = 1; f <= 3; f++) begin
      press(1'b1, 1'b0, 1'b0);
      chk("set_field_cycle", set_field, f);
      for (int s = 1; s <= 12; s++) begin
        step();
        en_cnt += int'(sec_en) + int'(min_en) + int'(hour_en);
`ifdef CLK_CTRL_BLINK_EN
        if (f == 1 && s == 4)  chk("blink_before_half", blink_on, 1);
        if (f == 1 && s == 5)  chk("blink_toggle_off", blink_on, 0);
        if (f == 1 && s == 10) chk("blink_toggle_on", blink_on, 1);
`else
        if (f == 1 && s == 5)  chk("blink_tied_high", blink_on, 1);
`endif
      end
    end
    chk("en_silent_in_set", en_cnt, 0);
    press(1'b1, 1'b0, 1'b0);
    chk("set_field_back_to_run", set_field, 0);
    wait_sec_en(n);
    chk("first_sec_en_after_set", n, CLK_DIV);

    // Set-mode step table
    for (int k = 0; k < 12; k++) begin
      for (int j = 0; j < int'(sv[k].field); j++) press(1'b1, 1'b0, 1'b0);
      chk("table_set_field", set_field, sv[k].field);
      case (sv[k].field)
        2'd1:    hour_bcd = sv[k].val;
        2'd2:    min_bcd  = sv[k].val;
        default: sec_bcd  = sv[k].val;
      endcase
      if (sv[k].exp_load) begin
        case (sv[k].field)
          2'd1:    exp_q.push_back({3'b100, sv[k].exp_data});
          2'd2:    exp_q.push_back({3'b010, sv[k].exp_data});
          default: exp_q.push_back({3'b001, sv[k].exp_data});
        endcase
      end
      press(1'b0, sv[k].inc, sv[k].dec);
      step(); step();
      for (int j = int'(sv[k].field); j < 4; j++) press(1'b1, 1'b0, 1'b0);
    end
    chk("table_back_to_run", set_field, 0);

    // Mode together with inc: advance, no load
    press(1'b1, 1'b0, 1'b0);
    hour_bcd = 8'h05;
    press(1'b1, 1'b1, 1'b0);
    chk("mode_wins_field", set_field, 2);
    step(); step();

    // Inc held two cycles: one load; held three cycles: guard then a second load
    min_bcd = 8'h09;
    exp_q.push_back({3'b010, 8'h10});
    key_inc = 1'b1; step(); step(); key_inc = 1'b0;
    step(); step();
    exp_q.push_back({3'b010, 8'h10});
    exp_q.push_back({3'b010, 8'h10});
    key_inc = 1'b1; step(); step(); step(); key_inc = 1'b0;
    step(); step();
    chk("guard_queue_drained", exp_q.size(), 0);

    // Reset mid SET_M with inc in flight
    key_inc = 1'b1;
    #2 rst_n = 1'b0;
    #1 key_inc = 1'b0;
    chk("rst_mid_set_load", min_load, 0);
    chk("rst_mid_set_field", set_field, 0);
    step(); step();
    chk("rst_hold_outputs", {sec_load, min_load, hour_load, set_field, blink_on}, {3'b000, 2'b00, 1'b1});
    rst_n = 1'b1;
    step(); step();
    chk("after_rst_field", set_field, 0);

    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
